// File: rtl/btb_tag_cam.sv
// Fully associative tag CAM for a branch target buffer: one-cycle lookup, dedup-on-insert, flush/invalidate.
// Define BTB_CAM_LRU_EN for age-based LRU replacement; the default build uses a round-robin pointer.
module btb_tag_cam #(
  parameter int TAG_WIDTH = 8,
  parameter int LINE_NUM  = 8,
  localparam int IDX_W    = $clog2(LINE_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lookup_valid,
  input  logic [TAG_WIDTH-1:0] lookup_tag,
  input  logic                 insert_valid,
  input  logic [TAG_WIDTH-1:0] insert_tag,
  input  logic                 inval_valid,
  input  logic [IDX_W-1:0]     inval_line,
  input  logic                 flush,
  output logic                 rsp_valid,
  output logic                 hit,
  output logic [IDX_W-1:0]     hit_line,
  output logic                 ins_done,
  output logic [IDX_W-1:0]     ins_line,
  output logic [IDX_W:0]       valid_count
);

  logic [LINE_NUM-1:0]  valid_q, valid_d;
  logic [TAG_WIDTH-1:0] tag_q [LINE_NUM];
  logic                 lk_hit, in_hit, free_any;
  logic [IDX_W-1:0]     lk_line, in_line, free_line, victim, ins_idx;
  logic                 do_ins, do_alloc;
  logic [IDX_W:0]       cnt_d;

`ifdef BTB_CAM_LRU_EN
  typedef logic [LINE_NUM-1:0][IDX_W-1:0] age_vec_t;
  age_vec_t age_q, age_d;

  // A line that was invalid is treated as the oldest, so every other line ages by one.
  function automatic age_vec_t touch(input age_vec_t a, input logic [IDX_W-1:0] idx,
                                     input logic fresh);
    age_vec_t         r;
    logic [IDX_W-1:0] ref_age;
    r       = a;
    ref_age = fresh ? '1 : a[idx];
    for (int unsigned i = 0; i < LINE_NUM; i++) begin
      if (IDX_W'(i) == idx)     r[i] = '0;
      else if (a[i] < ref_age)  r[i] = a[i] + 1'b1;
    end
    return r;
  endfunction
`else
  logic [IDX_W-1:0] rr_q;
`endif

  always_comb begin
    lk_hit    = 1'b0;
    lk_line   = '0;
    in_hit    = 1'b0;
    in_line   = '0;
    free_any  = 1'b0;
    free_line = '0;
    for (int unsigned i = 0; i < LINE_NUM; i++) begin
      if (!lk_hit && valid_q[i] && tag_q[i] == lookup_tag) begin
        lk_hit  = 1'b1;
        lk_line = IDX_W'(i);
      end
      if (!in_hit && valid_q[i] && tag_q[i] == insert_tag) begin
        in_hit  = 1'b1;
        in_line = IDX_W'(i);
      end
      if (!free_any && !valid_q[i]) begin
        free_any  = 1'b1;
        free_line = IDX_W'(i);
      end
    end
  end

`ifdef BTB_CAM_LRU_EN
  // Oldest line wins, lowest index on tie; equals the age LINE_NUM-1 line once ages are a permutation.
  always_comb begin
    logic [IDX_W-1:0] best;
    best   = '0;
    victim = '0;
    for (int unsigned i = 0; i < LINE_NUM; i++) begin
      if (age_q[i] > best) begin
        best   = age_q[i];
        victim = IDX_W'(i);
      end
    end
  end
`else
  assign victim = rr_q;
`endif

  assign ins_idx  = in_hit ? in_line : (free_any ? free_line : victim);
  assign do_ins   = insert_valid && !flush;
  assign do_alloc = do_ins && !in_hit;

  // Insert is applied after invalidate so it wins when both target one line.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      if (inval_valid) valid_d[inval_line] = 1'b0;
      if (do_ins)      valid_d[ins_idx]    = 1'b1;
    end
    cnt_d = '0;
    for (int unsigned i = 0; i < LINE_NUM; i++) begin
      cnt_d = cnt_d + (IDX_W+1)'(valid_d[i]);
    end
  end

`ifdef BTB_CAM_LRU_EN
  always_comb begin
    age_d = age_q;
    if (flush) begin
      age_d = '0;
    end else begin
      if (lookup_valid && lk_hit) age_d = touch(age_d, lk_line, 1'b0);
      if (do_ins)                 age_d = touch(age_d, ins_idx, !valid_q[ins_idx]);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      rsp_valid   <= 1'b0;
      hit         <= 1'b0;
      hit_line    <= '0;
      ins_done    <= 1'b0;
      ins_line    <= '0;
      valid_count <= '0;
`ifdef BTB_CAM_LRU_EN
      age_q       <= '0;
`else
      rr_q        <= '0;
`endif
    end else begin
      valid_q     <= valid_d;
      valid_count <= cnt_d;
      rsp_valid   <= lookup_valid;
      if (lookup_valid) begin
        hit      <= lk_hit;
        hit_line <= lk_line;
      end
      ins_done <= do_ins;
      if (do_ins) ins_line <= ins_idx;
`ifdef BTB_CAM_LRU_EN
      age_q <= age_d;
`else
      if (do_alloc && !free_any) rr_q <= rr_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_alloc) tag_q[ins_idx] <= insert_tag;
  end

endmodule

// File: tb/tb_btb_tag_cam.sv
// Directed self-checking bench for btb_tag_cam (8 lines, 8-bit tags); honours BTB_CAM_LRU_EN.
module tb_btb_tag_cam;

  logic       clk = 1'b0;
  logic       rst;
  logic       lookup_valid;
  logic [7:0] lookup_tag;
  logic       insert_valid;
  logic [7:0] insert_tag;
  logic       inval_valid;
  logic [2:0] inval_line;
  logic       flush;
  logic       rsp_valid;
  logic       hit;
  logic [2:0] hit_line;
  logic       ins_done;
  logic [2:0] ins_line;
  logic [3:0] valid_count;

  int n_cmp = 0;
  int n_err = 0;

  btb_tag_cam #(.TAG_WIDTH(8), .LINE_NUM(8)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_tag(lookup_tag),
    .insert_valid(insert_valid), .insert_tag(insert_tag),
    .inval_valid(inval_valid), .inval_line(inval_line),
    .flush(flush),
    .rsp_valid(rsp_valid), .hit(hit), .hit_line(hit_line),
    .ins_done(ins_done), .ins_line(ins_line), .valid_count(valid_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    lookup_valid = 1'b0; lookup_tag = '0;
    insert_valid = 1'b0; insert_tag = '0;
    inval_valid  = 1'b0; inval_line = '0;
    flush        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_insert(input logic [7:0] t);
    idle(); insert_valid = 1'b1; insert_tag = t; tick();
  endtask

  task automatic do_lookup(input logic [7:0] t);
    idle(); lookup_valid = 1'b1; lookup_tag = t; tick();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    // requests during reset must produce nothing
    lookup_valid = 1'b1; lookup_tag = 8'h5A; insert_valid = 1'b1; insert_tag = 8'h77;
    tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_hit", hit, 0);
    check("rst_hit_line", hit_line, 0);
    check("rst_ins_done", ins_done, 0);
    check("rst_ins_line", ins_line, 0);
    check("rst_valid_count", valid_count, 0);
    idle(); rst = 1'b0;

    do_lookup(8'h5A);
    check("miss_rsp_valid", rsp_valid, 1);
    check("miss_hit", hit, 0);
    check("miss_hit_line", hit_line, 0);
    check("miss_valid_count", valid_count, 0);
    idle(); tick();
    check("rsp_valid_drop", rsp_valid, 0);

    do_insert(8'h11);
    check("ins11_done", ins_done, 1);
    check("ins11_line", ins_line, 0);
    do_insert(8'h22);
    check("ins22_line", ins_line, 1);
    check("ins22_count", valid_count, 2);
    idle(); tick();
    check("ins_done_pulse", ins_done, 0);
    do_lookup(8'h22);
    check("lk22_hit", hit, 1);
    check("lk22_line", hit_line, 1);

    // flush with same-cycle insert and lookup of a resident tag
    idle(); flush = 1'b1; insert_valid = 1'b1; insert_tag = 8'h44;
    lookup_valid = 1'b1; lookup_tag = 8'h11; tick();
    check("flush_ins_done", ins_done, 0);
    check("flush_count", valid_count, 0);
    check("flush_lk_rsp", rsp_valid, 1);
    check("flush_lk_hit", hit, 1);
    check("flush_lk_line", hit_line, 0);
    do_lookup(8'h11);
    check("post_flush_hit", hit, 0);
    do_lookup(8'h44);
    check("flush_dropped_ins", hit, 0);

    for (int i = 0; i < 8; i++) begin
      do_insert(8'(i));
      check("fill_line", ins_line, 32'(i));
      check("fill_count", valid_count, 32'(i + 1));
    end
`ifdef BTB_CAM_LRU_EN
    do_lookup(8'h00);
    check("lru_lk00_hit", hit, 1);
    do_insert(8'h08);
    check("lru_ins08_line", ins_line, 1);
    check("lru_full_count", valid_count, 8);
    do_lookup(8'h08);
    check("lru_lk08_line", hit_line, 1);
    do_lookup(8'h01);
    check("lru_evicted01", hit, 0);
`else
    do_insert(8'h08);
    check("rr_ins08_line", ins_line, 0);
    check("rr_full_count", valid_count, 8);
    do_insert(8'h09);
    check("rr_ins09_line", ins_line, 1);
    do_lookup(8'h00);
    check("rr_evicted00", hit, 0);
    check("rr_evicted00_line", hit_line, 0);
    do_lookup(8'h09);
    check("rr_lk09_line", hit_line, 1);
`endif

    idle(); rst = 1'b1; tick(); rst = 1'b0;
    check("rst2_count", valid_count, 0);
    do_insert(8'h10);
    do_insert(8'h20);
    do_insert(8'h30);
    do_insert(8'h40);
    do_insert(8'h33);
    check("ins33_line", ins_line, 4);
    check("five_count", valid_count, 5);
    do_insert(8'h33);
    check("dup33_done", ins_done, 1);
    check("dup33_line", ins_line, 4);
    check("dup33_count", valid_count, 5);

    idle(); inval_valid = 1'b1; inval_line = 3'd2; tick();
    check("inval2_count", valid_count, 4);
    idle(); inval_valid = 1'b1; inval_line = 3'd2; tick();
    check("inval2_again", valid_count, 4);
    do_lookup(8'h30);
    check("inval2_miss", hit, 0);

    // invalidate and insert land on line 2 together; insert wins
    idle(); inval_valid = 1'b1; inval_line = 3'd2; insert_valid = 1'b1; insert_tag = 8'h55; tick();
    check("inv_ins_line", ins_line, 2);
    check("inv_ins_count", valid_count, 5);
    do_lookup(8'h55);
    check("lk55_hit", hit, 1);
    check("lk55_line", hit_line, 2);
    idle(); tick();
    check("hold_rsp", rsp_valid, 0);
    check("hold_hit", hit, 1);
    check("hold_line", hit_line, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btb_tag_cam.md
BTB_TAG_CAM -- requirements
Module: btb_tag_cam

Interface
REQ-001 The block SHALL have parameter TAG_WIDTH, default 8, meaning the tag width in bits.
REQ-002 The block SHALL have parameter LINE_NUM, default 8, meaning the number of lines (power of two, 2..64); IDX_W = log2(LINE_NUM).
REQ-003 The block SHALL have port clk, input, width 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1, meaning the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port lookup_valid, input, width 1, meaning a lookup request this cycle.
REQ-006 The block SHALL have port lookup_tag, input, width TAG_WIDTH, meaning the tag to search.
REQ-007 The block SHALL have port insert_valid, input, width 1, meaning an allocate request this cycle.
REQ-008 The block SHALL have port insert_tag, input, width TAG_WIDTH, meaning the tag to allocate.
REQ-009 The block SHALL have port inval_valid, input, width 1, meaning invalidate one line.
REQ-010 The block SHALL have port inval_line, input, width IDX_W, meaning the line to invalidate.
REQ-011 The block SHALL have port flush, input, width 1, meaning invalidate all lines.
REQ-012 The block SHALL have port rsp_valid, output, width 1, meaning the lookup result is valid this cycle.
REQ-013 The block SHALL have port hit, output, width 1, meaning the lookup matched a valid line.
REQ-014 The block SHALL have port hit_line, output, width IDX_W, meaning the matching line index.
REQ-015 The block SHALL have port ins_done, output, width 1, meaning the insert completed.
REQ-016 The block SHALL have port ins_line, output, width IDX_W, meaning the line written or reused by the insert.
REQ-017 The block SHALL have port valid_count, output, width IDX_W+1, meaning the number of valid lines.

Function
REQ-018 Lookup SHALL have a latency of one cycle: rsp_valid is asserted exactly one cycle after lookup_valid, and hit/hit_line are registered at the same time.
REQ-019 On multiple matches, the lowest-index valid match SHALL be reported.
REQ-020 On a miss, hit SHALL be 0 and hit_line SHALL be 0; no out-of-range index is ever produced.
REQ-021 When rsp_valid is 0, hit and hit_line SHALL hold their last values.
REQ-022 An insert whose tag already matches a valid line SHALL NOT duplicate that tag: ins_line is the existing line and the tag store is unchanged.
REQ-023 Otherwise the victim SHALL be the lowest-index invalid line; if all lines are valid, the victim is chosen by the replacement policy (REQ-033/034); the victim's tag is written and its valid bit is set.
REQ-024 ins_done and ins_line SHALL be registered and asserted one cycle after insert_valid; ins_done is a single-cycle pulse.
REQ-025 A lookup issued in the same cycle as an insert or invalidate SHALL see the pre-update state (read-before-write).
REQ-026 flush SHALL clear all valid bits next cycle; insert_valid and inval_valid in the same cycle SHALL be ignored (ins_done stays 0); a lookup in that cycle still responds against the old state.
REQ-027 When inval_valid and insert_valid target the same line in one cycle, the insert SHALL win and the line ends valid with insert_tag.
REQ-028 Invalidating an already invalid line SHALL be a no-op.
REQ-029 valid_count SHALL equal the popcount of the valid bits after each update, saturating range 0..LINE_NUM.

Reset
REQ-030 When rst is high at a clock edge, all valid bits SHALL clear and the replacement state SHALL go to its initial value (pointer 0 / ages 0).
REQ-031 During reset, rsp_valid, hit, hit_line, ins_done, ins_line and valid_count SHALL all be 0.
REQ-032 rst SHALL override flush, insert, invalidate and lookup; requests in flight at reset SHALL produce no response.

Configuration
REQ-033 With the macro BTB_CAM_LRU_EN undefined, the victim SHALL come from a round-robin pointer of IDX_W bits that advances by 1 (wrapping LINE_NUM-1 to 0) only on each full-table replacement.
REQ-034 With BTB_CAM_LRU_EN defined, each line SHALL keep an IDX_W-bit age; a lookup hit or an insert makes that line age 0 and increments all younger ages; the victim is the line with age LINE_NUM-1 (lowest index on tie); flush and reset zero all ages.

Verification
REQ-035 The bench SHALL cover: reset, then lookup tag 0x5A -> next cycle rsp_valid=1, hit=0, hit_line=0, valid_count=0.
REQ-036 The bench SHALL cover: insert 0x11, then 0x22 -> ins_line 0 then 1, valid_count=2; then lookup 0x22 -> hit=1, hit_line=1.
REQ-037 The bench SHALL cover: fill 8 lines with tags 0x00..0x07, then insert 0x08 -> round-robin build: ins_line=0, next 0x09 -> ins_line=1; LRU build after lookup of 0x00: ins_line=1.
REQ-038 The bench SHALL cover: insert 0x33 while 0x33 is valid in line 4 -> ins_line=4, valid_count unchanged.
REQ-039 The bench SHALL cover: flush together with insert 0x44 -> ins_done=0, valid_count=0 next cycle; a same-cycle lookup of a valid tag still reports hit=1.
REQ-040 The bench SHALL cover: inval_line=2 and insert 0x55 (victim line 2) in the same cycle -> line 2 valid with 0x55, and a following lookup 0x55 reports hit_line=2.
